spi_frontend: RTL and testbench

//  SPI peripheral front-end (mode 0, MSB first) feeding the bus block.

---
 rtl/spi_pkg.sv | 15 +
 rtl/sync_edge.sv | 34 +++
 rtl/spi_frontend.sv | 173 +++++++++++++++++
 tb/tb_spi_frontend.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI peripheral front-end: default word
// width, the word shifted out when the bus has nothing to send, and
// the front-end state encoding.
package spi_pkg;

  localparam int         DATA_W_DEF    = 8;
  localparam logic [7:0] IDLE_FILL_DEF = 8'hFF;

  typedef enum logic [1:0] {
    WAIT_IDLE,
    IDLE,
    ACTIVE
  } spi_state_t;

endpackage

// File: rtl/sync_edge.sv
// Multi-stage synchroniser for one asynchronous pin, with single-cycle
// rise and fall strobes taken from the synchronised level.
module sync_edge #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  // Shift the raw pin through the synchroniser chain and remember the
  // previous synchronised level so edges can be detected.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {STAGES{RESET_VAL}};
      prev_q <= RESET_VAL;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign level_o = sync_q[STAGES-1];
  assign rise_o  = sync_q[STAGES-1] & ~prev_q;
  assign fall_o  = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/spi_frontend.sv
// SPI mode-0 peripheral front-end. The raw SPI pins are oversampled in
// the clk domain; COPI is deserialised MSB first into words for the bus,
// and response words from the bus are serialised onto CIPO.
module spi_frontend
  import spi_pkg::*;
#(
  parameter int              DATA_W      = DATA_W_DEF,
  parameter int              SYNC_STAGES = 2,
  parameter logic [DATA_W-1:0] IDLE_FILL = DATA_W'(IDLE_FILL_DEF)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              spi_clk,
  input  logic              spi_cs,
  input  logic              spi_copi,
  output logic              spi_cipo,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic              rx_overrun,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              tx_underrun,
  output logic              frame_start,
  output logic              frame_end
);

  localparam int              CNT_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int              SETTLE_W = $clog2(SYNC_STAGES + 2);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  logic cs_s, cs_rise, cs_fall;
  logic sclk_level_unused, sclk_rise, sclk_fall;
  logic [SYNC_STAGES-1:0] copi_sync_q;
  logic copi_s;

  spi_state_t          state_q;
  logic [SETTLE_W-1:0] settle_q;
  logic [CNT_W-1:0]    bit_cnt_q;
  logic [DATA_W-1:0]   rx_shift_q, rx_data_q, tx_shift_q, hold_q;
  logic                rx_valid_q, rx_overrun_q, hold_full_q, tx_underrun_q;
  logic                frame_start_q, frame_end_q;
  logic [DATA_W-1:0]   rx_word;
  logic                tx_load, tx_write;

  sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_cs_sync (
    .clk(clk), .rst_n(rst_n), .d_i(spi_cs),
    .level_o(cs_s), .rise_o(cs_rise), .fall_o(cs_fall)
  );

  sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sclk_sync (
    .clk(clk), .rst_n(rst_n), .d_i(spi_clk),
    .level_o(sclk_level_unused), .rise_o(sclk_rise), .fall_o(sclk_fall)
  );

  // COPI uses the same depth as the clock synchroniser so the sampled
  // data bit lines up with the synchronised sclk rising edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      copi_sync_q <= '0;
    end else begin
      copi_sync_q <= {copi_sync_q[SYNC_STAGES-2:0], spi_copi};
    end
  end

  assign copi_s  = copi_sync_q[SYNC_STAGES-1];
  assign rx_word = {rx_shift_q[DATA_W-2:0], copi_s};

  // A tx word is loaded at frame start and at each later word boundary;
  // a boundary coinciding with CS rising is skipped so the holding
  // register is not consumed by a frame that is ending.
  assign tx_load  = ((state_q == IDLE) && cs_fall) ||
                    ((state_q == ACTIVE) && sclk_fall && (bit_cnt_q == '0) && !cs_rise);
  assign tx_write = tx_valid && !hold_full_q;

  // Front-end FSM with bit counter, shifters, holding register and the
  // registered handshake and pulse outputs. The synchroniser resets to
  // CS high, so WAIT_IDLE waits for the synchronised CS to stay high
  // long enough to have flushed the reset value before arming.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= WAIT_IDLE;
      settle_q      <= '0;
      bit_cnt_q     <= '0;
      rx_shift_q    <= '0;
      rx_data_q     <= '0;
      rx_valid_q    <= 1'b0;
      rx_overrun_q  <= 1'b0;
      tx_shift_q    <= '0;
      hold_q        <= '0;
      hold_full_q   <= 1'b0;
      tx_underrun_q <= 1'b0;
      frame_start_q <= 1'b0;
      frame_end_q   <= 1'b0;
    end else begin
      frame_start_q <= 1'b0;
      frame_end_q   <= 1'b0;
      rx_overrun_q  <= 1'b0;
      tx_underrun_q <= 1'b0;

      if (rx_valid_q && rx_ready) begin
        rx_valid_q <= 1'b0;
      end

      if (tx_write) begin
        hold_q      <= tx_data;
        hold_full_q <= 1'b1;
      end

      if (tx_load) begin
        if (hold_full_q) begin
          tx_shift_q  <= hold_q;
          hold_full_q <= 1'b0;
        end else begin
          tx_shift_q    <= IDLE_FILL;
          tx_underrun_q <= 1'b1;
        end
      end

      case (state_q)
        WAIT_IDLE: begin
          if (!cs_s) begin
            settle_q <= '0;
          end else if (settle_q == SETTLE_W'(SYNC_STAGES)) begin
            state_q  <= IDLE;
            settle_q <= '0;
          end else begin
            settle_q <= settle_q + 1'b1;
          end
        end
        IDLE: begin
          if (cs_fall) begin
            state_q       <= ACTIVE;
            frame_start_q <= 1'b1;
            bit_cnt_q     <= '0;
          end
        end
        ACTIVE: begin
          if (sclk_rise) begin
            rx_shift_q <= rx_word;
            bit_cnt_q  <= bit_cnt_q + 1'b1;
            if (bit_cnt_q == LAST_BIT) begin
              rx_data_q    <= rx_word;
              rx_valid_q   <= 1'b1;
              rx_overrun_q <= rx_valid_q && !rx_ready;
            end
          end
          if (sclk_fall && (bit_cnt_q != '0)) begin
            tx_shift_q <= {tx_shift_q[DATA_W-2:0], 1'b0};
          end
          if (cs_rise) begin
            state_q     <= IDLE;
            frame_end_q <= 1'b1;
            bit_cnt_q   <= '0;
            tx_shift_q  <= '0;
          end
        end
        default: state_q <= WAIT_IDLE;
      endcase
    end
  end

  assign spi_cipo    = (state_q == ACTIVE) && tx_shift_q[DATA_W-1];
  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign rx_overrun  = rx_overrun_q;
  assign tx_ready    = !hold_full_q;
  assign tx_underrun = tx_underrun_q;
  assign frame_start = frame_start_q;
  assign frame_end   = frame_end_q;

endmodule

// File: tb/tb_spi_frontend.sv
// Bench for spi_frontend: a bit-banged mode-0 controller drives the pins,
// expected rx words and CIPO words are queued as frames are issued, and
// independent monitors pop and compare as the DUT presents them.
module tb_spi_frontend;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       spi_clk, spi_cs, spi_copi;
  logic       spi_cipo;
  logic [7:0] rx_data;
  logic       rx_valid, rx_ready, rx_overrun;
  logic [7:0] tx_data;
  logic       tx_valid, tx_ready, tx_underrun;
  logic       frame_start, frame_end;

  int checks   = 0;
  int failures = 0;

  logic [7:0] rxExp[$];
  logic [7:0] txExp[$];

  int fsCnt = 0, feCnt = 0, ovCnt = 0, unCnt = 0, hsCnt = 0;
  int fsSnap, feSnap, ovSnap, unSnap, hsSnap;

  int         txBits = 0;
  logic [7:0] txWord = '0;

  // 50 MHz core clock
  always #10 clk = ~clk;

  spi_frontend dut (
    .clk(clk), .rst_n(rst_n),
    .spi_clk(spi_clk), .spi_cs(spi_cs), .spi_copi(spi_copi), .spi_cipo(spi_cipo),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_overrun(rx_overrun),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_underrun(tx_underrun),
    .frame_start(frame_start), .frame_end(frame_end)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  // Count every pulse output, sampled away from the active edge
  always @(negedge clk) begin
    if (frame_start) fsCnt++;
    if (frame_end)   feCnt++;
    if (rx_overrun)  ovCnt++;
    if (tx_underrun) unCnt++;
  end

  // Receive monitor: each accepted rx word is checked against the queue
  always @(negedge clk) begin
    if (rst_n && rx_valid && rx_ready) begin
      hsCnt++;
      if (rxExp.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL rx_unexpected: got 0x%0h expected no word", rx_data);
      end else begin
        checkOutput("rx_data", {24'd0, rx_data}, {24'd0, rxExp.pop_front()});
      end
    end
  end

  // CIPO monitor: the controller's view, sampled on raw spi_clk rises
  always @(posedge spi_clk or posedge spi_cs) begin
    if (spi_cs) begin
      txBits = 0;
    end else begin
      txWord = {txWord[6:0], spi_cipo};
      txBits++;
      if (txBits == 8) begin
        txBits = 0;
        if (txExp.size() > 0) begin
          checkOutput("cipo_word", {24'd0, txWord}, {24'd0, txExp.pop_front()});
        end
      end
    end
  end

  // spi_clk at 5 MHz: half period is five core clocks
  task automatic halfPeriod();
    repeat (5) @(negedge clk);
  endtask

  // One frame of nWords words; the last word carries lastBits bits.
  // CS is raised while spi_clk is still high, then spi_clk returns idle.
  task automatic applyStimulus(input logic [7:0] w0, input logic [7:0] w1,
                               input int nWords, input int lastBits);
    logic [7:0] w;
    int         nb;
    spi_cs = 1'b0;
    halfPeriod();
    for (int k = 0; k < nWords; k++) begin
      w  = (k == 0) ? w0 : w1;
      nb = (k == nWords - 1) ? lastBits : 8;
      for (int i = 0; i < nb; i++) begin
        spi_clk  = 1'b0;
        spi_copi = w[7-i];
        halfPeriod();
        spi_clk = 1'b1;
        halfPeriod();
      end
    end
    spi_cs = 1'b1;
    halfPeriod();
    spi_clk = 1'b0;
    halfPeriod();
    halfPeriod();
  endtask

  task automatic preloadTx(input logic [7:0] w);
    @(negedge clk);
    tx_data  = w;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  task automatic waitRxDrain();
    for (int i = 0; i < 200 && rxExp.size() > 0; i++) @(negedge clk);
    checkOutput("rx_drain_timeout", rxExp.size(), 0);
  endtask

  task automatic snapCounts();
    fsSnap = fsCnt; feSnap = feCnt; ovSnap = ovCnt; unSnap = unCnt; hsSnap = hsCnt;
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_cipo"},        spi_cipo,    0);
    checkOutput({tag, "_rx_data"},     rx_data,     0);
    checkOutput({tag, "_rx_valid"},    rx_valid,    0);
    checkOutput({tag, "_tx_ready"},    tx_ready,    1);
    checkOutput({tag, "_rx_overrun"},  rx_overrun,  0);
    checkOutput({tag, "_tx_underrun"}, tx_underrun, 0);
    checkOutput({tag, "_frame_start"}, frame_start, 0);
    checkOutput({tag, "_frame_end"},   frame_end,   0);
  endtask

  // Global watchdog so the run always ends
  initial begin
    #5ms;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n    = 1'b0;
    spi_clk  = 1'b0;
    spi_cs   = 1'b0;
    spi_copi = 1'b0;
    rx_ready = 1'b1;
    tx_data  = '0;
    tx_valid = 1'b0;

    // Test 1: CS already low when reset releases
    repeat (3) @(negedge clk);
    checkResetValues("reset");
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    checkOutput("no_start_while_cs_low", fsCnt, 0);
    spi_cs = 1'b1;
    repeat (10) @(negedge clk);
    snapCounts();
    spi_cs = 1'b0;
    repeat (10) @(negedge clk);
    checkOutput("rearm_frame_start", fsCnt - fsSnap, 1);
    spi_cs = 1'b1;
    repeat (10) @(negedge clk);
    checkOutput("rearm_frame_end", feCnt - feSnap, 1);

    // Test 2: preloaded response 0x3C while receiving 0xA5
    preloadTx(8'h3C);
    checkOutput("tx_ready_after_write", tx_ready, 0);
    snapCounts();
    rxExp.push_back(8'hA5);
    txExp.push_back(8'h3C);
    applyStimulus(8'hA5, 8'h00, 1, 8);
    waitRxDrain();
    checkOutput("t2_frame_start", fsCnt - fsSnap, 1);
    checkOutput("t2_frame_end",   feCnt - feSnap, 1);
    checkOutput("t2_rx_words",    hsCnt - hsSnap, 1);
    checkOutput("t2_underrun",    unCnt - unSnap, 0);
    checkOutput("t2_tx_ready",    tx_ready, 1);

    // Test 3: two words with rx_ready low overrun the first
    rx_ready = 1'b0;
    snapCounts();
    txExp.push_back(8'hFF);
    txExp.push_back(8'hFF);
    applyStimulus(8'h12, 8'h34, 2, 8);
    checkOutput("t3_overrun",  ovCnt - ovSnap, 1);
    checkOutput("t3_rx_data",  rx_data, 8'h34);
    checkOutput("t3_rx_valid", rx_valid, 1);
    checkOutput("t3_underrun", unCnt - unSnap, 2);
    rxExp.push_back(8'h34);
    rx_ready = 1'b1;
    waitRxDrain();
    checkOutput("t3_rx_words", hsCnt - hsSnap, 1);

    // Test 4: no response words, idle fill on CIPO twice
    snapCounts();
    rxExp.push_back(8'h55);
    rxExp.push_back(8'hAA);
    txExp.push_back(8'hFF);
    txExp.push_back(8'hFF);
    applyStimulus(8'h55, 8'hAA, 2, 8);
    waitRxDrain();
    checkOutput("t4_underrun", unCnt - unSnap, 2);
    checkOutput("t4_rx_words", hsCnt - hsSnap, 2);
    checkOutput("t4_overrun",  ovCnt - ovSnap, 0);

    // Test 5: aborted 5-bit frame, then a full 0x81
    snapCounts();
    applyStimulus(8'hB8, 8'h00, 1, 5);
    checkOutput("t5_partial_frame_end", feCnt - feSnap, 1);
    checkOutput("t5_partial_no_word",   hsCnt - hsSnap, 0);
    checkOutput("t5_partial_rx_valid",  rx_valid, 0);
    rxExp.push_back(8'h81);
    txExp.push_back(8'hFF);
    applyStimulus(8'h81, 8'h00, 1, 8);
    waitRxDrain();
    checkOutput("t5_rx_data", rx_data, 8'h81);
    checkOutput("t5_rx_words", hsCnt - hsSnap, 1);

    // Test 6: asynchronous reset in the middle of a word
    spi_cs = 1'b0;
    halfPeriod();
    for (int i = 0; i < 4; i++) begin
      spi_clk  = 1'b0;
      spi_copi = 1'b1;
      halfPeriod();
      spi_clk = 1'b1;
      halfPeriod();
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkResetValues("midreset");
    snapCounts();
    spi_cs = 1'b1;
    halfPeriod();
    spi_clk = 1'b0;
    halfPeriod();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    checkOutput("t6_no_frame_end", feCnt - feSnap, 0);
    preloadTx(8'h5A);
    checkOutput("t6_tx_ready", tx_ready, 0);
    snapCounts();
    rxExp.push_back(8'hC3);
    txExp.push_back(8'h5A);
    applyStimulus(8'hC3, 8'h00, 1, 8);
    waitRxDrain();
    checkOutput("t6_rx_data",  rx_data, 8'hC3);
    checkOutput("t6_underrun", unCnt - unSnap, 0);
    checkOutput("t6_frames",   fsCnt - fsSnap, 1);

    checkOutput("tx_queue_empty", txExp.size(), 0);
    checkOutput("rx_queue_empty", rxExp.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
